uart_rx_ctrl: RTL and testbench

//  Receive-side sequencer for the UART serial-in/parallel-out datapath.
//  - Synchronises rx and qualifies the start bit.
//  - Times mid-bit sampling from an oversample tick.
//  - Drives the SIPO shift/hold control and counts data bits.
//  - Checks the stop bit and presents each byte on a valid/ready handshake.
//  - Sits between the baud/oversample tick generator and the receive FIFO/consumer.

---
 rtl/uart_rx_ctrl_if.sv | 30 +++
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Receive-controller signal bundle: tick/serial input, byte handshake, SIPO control and error pulses.
// master = the receive controller, slave = the tick source / consumer side.
interface uart_rx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             sample_tick;
    logic             rx;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             shift_en;
    logic             hold_value;
    logic [3:0]       bit_count;
    logic             busy;
    logic             frame_err;
    logic             overrun_err;
    logic             parity_err;

    modport master (
        input  sample_tick, rx, rx_ready,
        output rx_data, rx_valid, shift_en, hold_value, bit_count,
               busy, frame_err, overrun_err, parity_err
    );

    modport slave (
        output sample_tick, rx, rx_ready,
        input  rx_data, rx_valid, shift_en, hold_value, bit_count,
               busy, frame_err, overrun_err, parity_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: rx synchroniser, start qualification, mid-bit sampling, SIPO control,
// stop check and valid/ready output buffer. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_ctrl #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_ctrl_if.master bus
);
    localparam int             TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_rx_sync;
    logic [TW-1:0]    r_tick_cnt;
    logic [3:0]       r_bit_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_in;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;

    logic w_tick_mid;
    logic w_tick_last;
    logic w_shift;
    logic w_stop_pt;
    logic w_par_bad;
    logic w_accept;
    logic w_overrun;

    assign w_tick_mid  = bus.sample_tick && (r_tick_cnt == TICK_MID);
    assign w_tick_last = bus.sample_tick && (r_tick_cnt == TICK_LAST);
    assign w_shift     = (r_state == S_DATA) && w_tick_last;
    assign w_stop_pt   = (r_state == S_STOP) && w_tick_last;

`ifdef UART_RX_PARITY_EN
    logic r_parity_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity_bit <= 1'b0;
        end else if ((r_state == S_PARITY) && w_tick_last) begin
            r_parity_bit <= r_rx_sync;
        end
    end

    // Even parity: data bits plus the parity bit must XOR to zero.
    assign w_par_bad = (^r_shift) ^ r_parity_bit;
`else
    assign w_par_bad = 1'b0;
`endif

    // A good frame is stored if the buffer is free or is being drained this very cycle.
    assign w_accept  = w_stop_pt && r_rx_sync && !w_par_bad && (!r_rx_valid || bus.rx_ready);
    assign w_overrun = w_stop_pt && r_rx_sync && !w_par_bad && r_rx_valid && !bus.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_sync1   <= bus.rx;
            r_rx_sync <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) w_state_next = S_START;
                end
                S_START: begin
                    if (w_tick_mid) w_state_next = r_rx_sync ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_tick_last && (r_bit_count == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick_last) w_state_next = S_STOP;
                end
`endif
                S_STOP: begin
                    if (w_tick_last) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Counter restarts on every state change so each state measures from its own entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
            r_tick_cnt <= '0;
        end else if (bus.sample_tick) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_count <= 4'd0;
        end else if ((w_state_next == S_START) && (r_state != S_START)) begin
            r_bit_count <= 4'd0;
        end else if (w_shift) begin
            r_bit_count <= r_bit_count + 4'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign w_shift_in[gi] = r_rx_sync;
            end else begin : g_body
                assign w_shift_in[gi] = r_shift[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '1;
        end else if (w_shift) begin
            r_shift <= w_shift_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rx_data <= r_shift;
            end
            if (w_accept) begin
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rx_data     = r_rx_data;
        bus.rx_valid    = r_rx_valid;
        bus.bit_count   = r_bit_count;
        bus.busy        = (r_state != S_IDLE);
        bus.shift_en    = w_shift;
        bus.hold_value  = !w_shift;
        bus.frame_err   = w_stop_pt && !r_rx_sync;
        bus.parity_err  = w_stop_pt && w_par_bad;
        bus.overrun_err = w_overrun;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame-level reference model feeds an expected-event queue,
// an independent monitor pops and compares on every DUT output event.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int WIDTH  = 8;
    localparam int OS     = 16;
    localparam int K_BYTE = 0;
    localparam int K_FRM  = 1;
    localparam int K_OVR  = 2;
    localparam int K_PAR  = 3;

    typedef struct {
        int               kind;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();

    uart_rx_ctrl #(.WIDTH(WIDTH), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   shift_cnt  = 0;
    int   exp_shift  = 0;
    int   tick_div   = 1;
    bit   mon_en     = 1'b0;
    bit   model_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick source: every cycle, or every other cycle when tick_div==2.
    initial begin
        bus.sample_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.sample_tick = (tick_div == 1) ? 1'b1 : ~bus.sample_tick;
        end
    end

    // Frame-level reference: outcome depends only on stop bit, parity and buffer occupancy.
    task automatic model_frame(input logic [WIDTH-1:0] d, input bit stop, input bit par_ok);
        exp_t e;
        bit   p_ok;
        p_ok = par_ok;
`ifndef UART_RX_PARITY_EN
        p_ok = 1'b1;
`endif
        e.data = '0;
        if (!stop || !p_ok) begin
            if (!stop) begin
                e.kind = K_FRM;
                exp_q.push_back(e);
            end
            if (!p_ok) begin
                e.kind = K_PAR;
                exp_q.push_back(e);
            end
        end else if (model_full) begin
            e.kind = K_OVR;
            exp_q.push_back(e);
        end else begin
            e.kind = K_BYTE;
            e.data = d;
            exp_q.push_back(e);
            model_full = 1'b1;
        end
    endtask

    task automatic hold_bit(input logic v);
        bus.rx = v;
        repeat (OS * tick_div) step();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d, input bit stop, input bit par_ok);
        model_frame(d, stop, par_ok);
        exp_shift += WIDTH;
        hold_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par_ok ? (^d) : ~(^d));
`endif
        hold_bit(stop);
        bus.rx = 1'b1;
        // A low stop bit would otherwise look like the next start edge.
        if (!stop) repeat (OS * tick_div) step();
    endtask

    task automatic drain();
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        model_full = 1'b0;
        check("drain_rx_valid", bus.rx_valid, 1'b0);
    endtask

    task automatic expect_evt(input int kind, input logic [WIDTH-1:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none at %0t",
                     kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == K_BYTE) check("rx_data", data, e.data);
            $display("event kind=%0d data=0x%0h at %0t", kind, data, $time);
        end
    endtask

    // Monitor: decoupled from stimulus, compares every output event against the queue head.
    initial begin
        logic             pv;
        logic             pr;
        logic [WIDTH-1:0] pd;
        logic             he;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.shift_en === 1'b1) shift_cnt++;
                he = ~bus.shift_en;
                check("hold_value", bus.hold_value, he);
                if (bus.frame_err === 1'b1)   expect_evt(K_FRM, '0);
                if (bus.parity_err === 1'b1)  expect_evt(K_PAR, '0);
                if (bus.overrun_err === 1'b1) expect_evt(K_OVR, '0);
                if (bus.rx_valid === 1'b1 && (!pv || pr)) expect_evt(K_BYTE, bus.rx_data);
                else check("rx_data_stable", bus.rx_data, pd);
            end
            pv = bus.rx_valid;
            pr = bus.rx_ready;
            pd = bus.rx_data;
        end
    end

    initial begin
        int base;
        int snap;
        logic [WIDTH-1:0] d;
        bit stop;
        bit par_ok;

        bus.rx       = 1'b1;
        bus.rx_ready = 1'b0;
        reset        = 1'b1;
        repeat (3) step();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_hold_value", bus.hold_value, 1'b1);
        check("rst_bit_count", bus.bit_count, 4'd0);
        check("rst_rx_data", bus.rx_data, '0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (4) step();

        // Fill the buffer, then reset in the middle of a following frame.
        send_frame(8'h96, 1'b1, 1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        check("mid_data_busy", bus.busy, 1'b1);
        mon_en = 1'b0;
        reset  = 1'b1;
        bus.rx = 1'b1;
        step();
        step();
        check("reset_busy", bus.busy, 1'b0);
        check("reset_rx_valid", bus.rx_valid, 1'b0);
        check("reset_hold_value", bus.hold_value, 1'b1);
        check("reset_bit_count", bus.bit_count, 4'd0);
        reset      = 1'b0;
        model_full = 1'b0;
        repeat (OS) step();
        mon_en    = 1'b1;
        base      = shift_cnt;
        exp_shift = 0;

        send_frame(8'h5A, 1'b1, 1'b1);
        drain();

        snap = shift_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        check("a5_shift_pulses", shift_cnt - snap, WIDTH);
        check("a5_rx_data", bus.rx_data, 8'hA5);
        check("a5_rx_valid", bus.rx_valid, 1'b1);
        drain();

        // Short low glitch is a false start.
        snap = shift_cnt;
        bus.rx = 1'b0;
        repeat (4) step();
        bus.rx = 1'b1;
        repeat (2 * OS) step();
        check("glitch_busy", bus.busy, 1'b0);
        check("glitch_rx_valid", bus.rx_valid, 1'b0);
        check("glitch_shift_pulses", shift_cnt - snap, 0);

        send_frame(8'h3C, 1'b0, 1'b1);
        check("frame_err_rx_valid", bus.rx_valid, 1'b0);
        check("frame_err_rx_data", bus.rx_data, 8'hA5);

        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        check("overrun_rx_data", bus.rx_data, 8'h11);
        drain();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_bad_rx_valid", bus.rx_valid, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_rx_data", bus.rx_data, 8'h07);
        check("par_ok_rx_valid", bus.rx_valid, 1'b1);
        drain();
`endif

        for (int n = 0; n < 40; n++) begin
            d      = WIDTH'($urandom);
            stop   = ($urandom_range(0, 9) != 0);
            par_ok = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) drain();
            tick_div = ($urandom_range(0, 3) == 0) ? 2 : 1;
            send_frame(d, stop, par_ok);
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 40)) step();
        end
        tick_div = 1;

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step();
        repeat (4) step();
        check("queue_drained", exp_q.size(), 0);
        check("total_shift_pulses", shift_cnt - base, exp_shift);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
